// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic-unit command issuer.
//   - ALU function codes driven on ALU_FUN
//   - response error codes returned on rsp_err
//   - issuer FSM state encoding (also visible on the debug state output)
package arith_pkg;

   localparam logic [1:0] FUN_ADD = 2'b00;
   localparam logic [1:0] FUN_SUB = 2'b01;
   localparam logic [1:0] FUN_MUL = 2'b10;
   localparam logic [1:0] FUN_DIV = 2'b11;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_DIV0    = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

endpackage

// File: rtl/arith_cmd_issuer.sv
// Initiator-side controller for the 16-bit signed arithmetic unit.
// Accepts one command at a time from the host, issues it to the arithmetic
// unit for a single cycle, waits for Arith_Flag (bounded by TIMEOUT), and
// returns the captured result with an error code.
//
// Ports:
//   CLK, rst                       clock, async active-high reset
//   cmd_valid/cmd_ready            host command handshake
//   cmd_a, cmd_b, cmd_fun          command operands and function code
//   A, B, ALU_FUN, ARITH_Enable    drive to the arithmetic unit
//   ARITH_OUT, Arith_Flag          result and result-valid from the unit
//   rsp_valid/rsp_ready            host response handshake
//   rsp_data, rsp_err              response payload
//   ops_done                       wrapping count of handed-off responses
//   dbg_state_o                    current FSM state
//
// Handshakes: a transfer happens on a rising CLK edge where valid && ready.
// Once raised, valid holds and its payload stays stable until that transfer.
module arith_cmd_issuer
   import arith_pkg::*;
#(
   parameter int IN_DATA_WIDTH   = 16,
   parameter int ARITH_OUT_WIDTH = 32,
   parameter int TIMEOUT         = 4,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                       CLK,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [IN_DATA_WIDTH-1:0]   cmd_a,
   input  logic [IN_DATA_WIDTH-1:0]   cmd_b,
   input  logic [1:0]                 cmd_fun,
   output logic [IN_DATA_WIDTH-1:0]   A,
   output logic [IN_DATA_WIDTH-1:0]   B,
   output logic [1:0]                 ALU_FUN,
   output logic                       ARITH_Enable,
   input  logic [ARITH_OUT_WIDTH-1:0] ARITH_OUT,
   input  logic                       Arith_Flag,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [ARITH_OUT_WIDTH-1:0] rsp_data,
   output logic [1:0]                 rsp_err,
   output logic [CNT_WIDTH-1:0]       ops_done,
   output state_e                     dbg_state_o
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_e                     state_q, state_d;
   logic [IN_DATA_WIDTH-1:0]   a_q, a_d;
   logic [IN_DATA_WIDTH-1:0]   b_q, b_d;
   logic [1:0]                 fun_q, fun_d;
   logic [ARITH_OUT_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [1:0]                 rsp_err_q, rsp_err_d;
   logic [CNT_WIDTH-1:0]       ops_q, ops_d;
   logic [TMO_W-1:0]           tmo_q, tmo_d;

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         fun_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= ERR_OK;
         ops_q      <= '0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         fun_q      <= fun_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         ops_q      <= ops_d;
         tmo_q      <= tmo_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      fun_d      = fun_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      ops_d      = ops_q;
      tmo_d      = tmo_q;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               a_d   = cmd_a;
               b_d   = cmd_b;
               fun_d = cmd_fun;
               // Divide-by-zero is screened here so the unit never sees it.
               if (cmd_fun == FUN_DIV && cmd_b == '0) begin
                  rsp_data_d = '0;
                  rsp_err_d  = ERR_DIV0;
                  state_d    = ST_RESP;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            tmo_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // The flag takes priority over an expiring timeout.
            if (Arith_Flag) begin
               rsp_data_d = ARITH_OUT;
               rsp_err_d  = ERR_OK;
               state_d    = ST_RESP;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
               if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                  rsp_data_d = '0;
                  rsp_err_d  = ERR_TIMEOUT;
                  state_d    = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               ops_d   = ops_q + CNT_WIDTH'(1);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cmd_ready    = (state_q == ST_IDLE);
   assign ARITH_Enable = (state_q == ST_ISSUE);
   assign rsp_valid    = (state_q == ST_RESP);
   assign A            = a_q;
   assign B            = b_q;
   assign ALU_FUN      = fun_q;
   assign rsp_data     = rsp_data_q;
   assign rsp_err      = rsp_err_q;
   assign ops_done     = ops_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_arith_cmd_issuer.sv
// Bench for arith_cmd_issuer paired with a behavioural arithmetic unit.
// stub_mode forces Arith_Flag low to emulate an unresponsive unit.
module tb_arith_cmd_issuer;
   import arith_pkg::*;

   localparam int TIMEOUT = 4;

   logic        CLK;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic [1:0]  cmd_fun;
   logic [15:0] A;
   logic [15:0] B;
   logic [1:0]  ALU_FUN;
   logic        ARITH_Enable;
   logic [31:0] ARITH_OUT;
   logic        Arith_Flag;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_err;
   logic [15:0] ops_done;
   state_e      dbg_state;

   logic        stub_mode;
   logic        alu_flag;
   logic [31:0] alu_out;

   logic [33:0] exp_q[$];
   logic [15:0] exp_ops;
   int          n_checks;
   int          n_fail;

   arith_cmd_issuer #(
      .IN_DATA_WIDTH(16), .ARITH_OUT_WIDTH(32), .TIMEOUT(TIMEOUT), .CNT_WIDTH(16)
   ) dut (
      .CLK(CLK), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
      .A(A), .B(B), .ALU_FUN(ALU_FUN), .ARITH_Enable(ARITH_Enable),
      .ARITH_OUT(ARITH_OUT), .Arith_Flag(Arith_Flag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .ops_done(ops_done), .dbg_state_o(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // ---------------- reference arithmetic ----------------
   function automatic logic [31:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic [1:0] f);
      logic signed [31:0] sa, sb, r;
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      case (f)
         FUN_ADD: r = sa + sb;
         FUN_SUB: r = sa - sb;
         FUN_MUL: r = sa * sb;
         default: r = (sb == 0) ? 32'sd0 : sa / sb;
      endcase
      return r;
   endfunction

   // Behavioural arithmetic unit: registered result, flag one cycle after enable.
   always @(posedge CLK or posedge rst) begin
      if (rst) begin
         alu_flag <= 1'b0;
         alu_out  <= '0;
      end else begin
         alu_flag <= ARITH_Enable;
         if (ARITH_Enable) alu_out <= alu_model(A, B, ALU_FUN);
      end
   end
   assign ARITH_OUT  = alu_out;
   assign Arith_Flag = stub_mode ? 1'b0 : alu_flag;

   // ---------------- scoreboard ----------------
   always @(negedge CLK) begin
      if (!rst && rsp_valid && rsp_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rsp: got err=%0h data=%08h, no response expected",
                     rsp_err, rsp_data);
         end else begin
            logic [33:0] e;
            e = exp_q.pop_front();
            if ({rsp_err, rsp_data} !== e) begin
               n_fail++;
               $display("FAIL rsp_payload: got err=%0h data=%08h, expected err=%0h data=%08h",
                        rsp_err, rsp_data, e[33:32], e[31:0]);
            end
         end
         exp_ops++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_cmd(input logic [15:0] a, input logic [15:0] b, input logic [1:0] f,
                           input logic [33:0] exp, input bit push);
      int guard;
      guard = 0;
      @(posedge CLK); #1;
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_fun   = f;
      @(negedge CLK);
      while (!cmd_ready && guard < 100) begin
         @(negedge CLK);
         guard++;
      end
      if (!cmd_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL cmd_accept_timeout: cmd_ready=%0b, expected 1 within 100 cycles",
                  cmd_ready);
      end
      @(posedge CLK);
      if (push) exp_q.push_back(exp);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 300) begin
         @(negedge CLK);
         guard++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge CLK);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge CLK);
      n_checks++;
      if ({cmd_ready, ARITH_Enable, rsp_valid} !== 3'b100 || A !== 16'd0 || B !== 16'd0 ||
          ALU_FUN !== 2'd0 || rsp_data !== 32'd0 || rsp_err !== 2'd0 || ops_done !== 16'd0 ||
          dbg_state !== ST_IDLE) begin
         n_fail++;
         $display("FAIL reset_values: rdy=%0b en=%0b vld=%0b A=%h B=%h fun=%0h data=%h err=%0h ops=%0d st=%0d, expected rdy=1 rest 0",
                  cmd_ready, ARITH_Enable, rsp_valid, A, B, ALU_FUN, rsp_data, rsp_err,
                  ops_done, dbg_state);
      end
   endtask

   task automatic test_add();
      int en_cnt;
      en_cnt    = 0;
      rsp_ready = 1'b1;
      send_cmd(16'd100, -16'sd30, FUN_ADD, {ERR_OK, 32'd70}, 1'b1);
      for (int i = 1; i <= 3; i++) begin
         @(negedge CLK);
         if (ARITH_Enable) en_cnt++;
         if (i == 1) begin
            n_checks++;
            if (A !== 16'd100 || B !== 16'hFFE2 || ALU_FUN !== FUN_ADD || !ARITH_Enable) begin
               n_fail++;
               $display("FAIL add_issue: en=%0b A=%h B=%h fun=%0h, expected en=1 A=0064 B=ffe2 fun=0",
                        ARITH_Enable, A, B, ALU_FUN);
            end
         end
         n_checks++;
         if (rsp_valid !== (i == 3)) begin
            n_fail++;
            $display("FAIL add_latency: cycle N+%0d rsp_valid=%0b, expected %0b",
                     i, rsp_valid, (i == 3));
         end
      end
      n_checks++;
      if (en_cnt != 1) begin
         n_fail++;
         $display("FAIL add_enable_width: enable high %0d cycles, expected 1", en_cnt);
      end
      @(negedge CLK);
      n_checks++;
      if (ops_done !== 16'd1 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL add_ops_done: ops_done=%0d rsp_valid=%0b, expected 1 and 0",
                  ops_done, rsp_valid);
      end
   endtask

   task automatic test_mul();
      rsp_ready = 1'b1;
      send_cmd(-16'sd300, 16'd200, FUN_MUL, {ERR_OK, 32'hFFFF15A0}, 1'b1);
      drain();
   endtask

   task automatic test_div();
      rsp_ready = 1'b1;
      send_cmd(-16'sd7, 16'd2, FUN_DIV, {ERR_OK, 32'hFFFFFFFD}, 1'b1);
      drain();
      send_cmd(16'd7, 16'd0, FUN_DIV, {ERR_DIV0, 32'd0}, 1'b1);
      @(negedge CLK);
      n_checks++;
      if (rsp_valid !== 1'b1 || ARITH_Enable !== 1'b0) begin
         n_fail++;
         $display("FAIL div0_latency: rsp_valid=%0b en=%0b at N+1, expected 1 and 0",
                  rsp_valid, ARITH_Enable);
      end
      @(negedge CLK);
      n_checks++;
      if (ops_done !== exp_ops || ARITH_Enable !== 1'b0) begin
         n_fail++;
         $display("FAIL div0_ops: ops_done=%0d en=%0b, expected %0d and 0",
                  ops_done, ARITH_Enable, exp_ops);
      end
   endtask

   task automatic test_backpressure();
      int guard;
      guard     = 0;
      rsp_ready = 1'b0;
      send_cmd(16'd5, 16'd3, FUN_SUB, {ERR_OK, 32'd2}, 1'b1);
      // Second command offered while the first response is blocked.
      #1;
      cmd_valid = 1'b1;
      cmd_a     = 16'd9;
      cmd_b     = 16'd4;
      cmd_fun   = FUN_ADD;
      while (!rsp_valid && guard < 20) begin
         @(negedge CLK);
         guard++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== 32'd2 || rsp_err !== ERR_OK ||
             cmd_ready !== 1'b0 || ARITH_Enable !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: vld=%0b data=%0d err=%0h rdy=%0b en=%0b, expected 1 2 0 0 0",
                     rsp_valid, rsp_data, rsp_err, cmd_ready, ARITH_Enable);
         end
      end
      @(posedge CLK); #1;
      rsp_ready = 1'b1;
      @(negedge CLK);     // handoff cycle
      n_checks++;
      if (cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_early_accept: cmd_ready=%0b in handoff cycle, expected 0", cmd_ready);
      end
      @(negedge CLK);     // first cycle after handoff
      n_checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_next_accept: cmd_ready=%0b rsp_valid=%0b, expected 1 and 0",
                  cmd_ready, rsp_valid);
      end
      @(posedge CLK);
      exp_q.push_back({ERR_OK, 32'd13});
      #1;
      cmd_valid = 1'b0;
      drain();
   endtask

   task automatic test_timeout();
      rsp_ready = 1'b1;
      stub_mode = 1'b1;
      send_cmd(16'd3, 16'd4, FUN_ADD, {ERR_TIMEOUT, 32'd0}, 1'b1);
      for (int i = 1; i <= TIMEOUT + 2; i++) begin
         @(negedge CLK);
         n_checks++;
         if (rsp_valid !== (i == TIMEOUT + 2)) begin
            n_fail++;
            $display("FAIL timeout_latency: cycle N+%0d rsp_valid=%0b, expected %0b",
                     i, rsp_valid, (i == TIMEOUT + 2));
         end
      end
      drain();
      stub_mode = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit saw_valid;
      saw_valid = 1'b0;
      rsp_ready = 1'b1;
      stub_mode = 1'b1;
      send_cmd(16'd10, 16'd20, FUN_ADD, '0, 1'b0);
      @(negedge CLK);
      @(negedge CLK);
      n_checks++;
      if (dbg_state !== ST_WAIT) begin
         n_fail++;
         $display("FAIL rst_mid_setup: state=%0d, expected %0d", dbg_state, ST_WAIT);
      end
      #2;
      rst     = 1'b1;
      exp_ops = '0;
      #1;
      n_checks++;
      if ({cmd_ready, ARITH_Enable, rsp_valid} !== 3'b100 || A !== 16'd0 || B !== 16'd0 ||
          ALU_FUN !== 2'd0 || rsp_data !== 32'd0 || rsp_err !== 2'd0 || ops_done !== 16'd0 ||
          dbg_state !== ST_IDLE) begin
         n_fail++;
         $display("FAIL rst_mid_values: rdy=%0b en=%0b vld=%0b A=%h B=%h fun=%0h data=%h err=%0h ops=%0d st=%0d, expected rdy=1 rest 0",
                  cmd_ready, ARITH_Enable, rsp_valid, A, B, ALU_FUN, rsp_data, rsp_err,
                  ops_done, dbg_state);
      end
      @(negedge CLK);
      @(negedge CLK);
      rst       = 1'b0;
      stub_mode = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (rsp_valid) saw_valid = 1'b1;
      end
      n_checks++;
      if (saw_valid || ops_done !== 16'd0) begin
         n_fail++;
         $display("FAIL rst_mid_no_rsp: saw_valid=%0b ops_done=%0d, expected 0 and 0",
                  saw_valid, ops_done);
      end
   endtask

   task automatic test_back_to_back();
      bit stop;
      stop = 1'b0;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               logic [15:0] a, b;
               logic [1:0]  f;
               logic [33:0] e;
               a = 16'($urandom_range(0, 65535));
               b = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(0, 65535));
               f = 2'($urandom_range(0, 3));
               if (f == FUN_DIV && b == 16'd0) e = {ERR_DIV0, 32'd0};
               else                            e = {ERR_OK, alu_model(a, b, f)};
               send_cmd(a, b, f, e, 1'b1);
            end
            stop = 1'b1;
         end
         begin
            while (!stop) begin
               @(posedge CLK); #1;
               rsp_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      rsp_ready = 1'b1;
      drain();
      n_checks++;
      if (ops_done !== exp_ops) begin
         n_fail++;
         $display("FAIL b2b_ops_done: ops_done=%0d, expected %0d", ops_done, exp_ops);
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      exp_ops   = '0;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_fun   = '0;
      rsp_ready = 1'b0;
      stub_mode = 1'b0;
      test_reset();
      @(negedge CLK);
      rst = 1'b0;
      test_add();
      test_mul();
      test_div();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/arith_cmd_issuer.md
Name: arith_cmd_issuer

Overview:
Initiator-side controller for the 16-bit signed arithmetic unit. It accepts operation commands from a host over a valid/ready handshake and drives A, B, ALU_FUN and ARITH_Enable for one issue cycle. It waits for Arith_Flag, captures the 32-bit ARITH_OUT, and returns the result with an error code over a second valid/ready handshake. It sits between the command decoder and the arithmetic unit and handles divide-by-zero screening and timeout.

Parameters:
IN_DATA_WIDTH, 16, operand width (signed)
ARITH_OUT_WIDTH, 32, result width (signed)
TIMEOUT, 4, max WAIT cycles without Arith_Flag before timeout error (>=1)
CNT_WIDTH, 16, width of completed-operation counter

Ports:
CLK  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  issuer can accept command
cmd_a  in  IN_DATA_WIDTH  operand A (signed)
cmd_b  in  IN_DATA_WIDTH  operand B (signed)
cmd_fun  in  2  00 add, 01 sub, 10 mul, 11 div
A  out  IN_DATA_WIDTH  operand to arithmetic unit
B  out  IN_DATA_WIDTH  operand to arithmetic unit
ALU_FUN  out  2  function to arithmetic unit
ARITH_Enable  out  1  issue strobe to arithmetic unit
ARITH_OUT  in  ARITH_OUT_WIDTH  registered result from arithmetic unit
Arith_Flag  in  1  result-valid flag from arithmetic unit
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_data  out  ARITH_OUT_WIDTH  captured result (signed)
rsp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout
ops_done  out  CNT_WIDTH  count of responses handed off, wraps

Behaviour:
- Interface: one clock, CLK. Reset rst is asynchronous and active-high; no synchronous reset path.
- Reset values: state IDLE; cmd_ready=1; A=0, B=0, ALU_FUN=0, ARITH_Enable=0; rsp_valid=0, rsp_data=0, rsp_err=0; ops_done=0; timeout counter=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: cmd_ready=1.
  - On cmd_valid&&cmd_ready, register cmd_a/cmd_b/cmd_fun into A/B/ALU_FUN.
  - If cmd_fun==11 and cmd_b==0, go to RESP with rsp_data=0, rsp_err=01. ARITH_Enable is never asserted for this command.
  - Otherwise go to ISSUE.
- ISSUE: exactly one cycle. ARITH_Enable=1; A/B/ALU_FUN stable. Next state WAIT; clear the timeout counter.
- WAIT: ARITH_Enable=0; A/B/ALU_FUN held.
  - If Arith_Flag=1, capture ARITH_OUT into rsp_data, set rsp_err=00, go to RESP.
  - Else increment the counter. When the counter reaches TIMEOUT, set rsp_data=0, rsp_err=10, go to RESP.
  - Arith_Flag and the timeout in the same cycle: the flag wins.
- RESP: rsp_valid=1, cmd_ready=0.
  - rsp_data/rsp_err hold stable while rsp_ready=0 (unbounded backpressure).
  - On rsp_valid&&rsp_ready: rsp_valid drops next cycle, ops_done increments (wraps modulo 2^CNT_WIDTH), go to IDLE.
  - rsp_data and rsp_err retain their last values after handoff.
- Latency: with a compliant arithmetic unit, acceptance edge N → ISSUE in cycle N+1 → WAIT in N+2 (flag high) → rsp_valid in N+3. Div-by-zero: rsp_valid in N+1.
- Throughput: one command in flight. cmd_ready=0 in ISSUE/WAIT/RESP. Next acceptance is no earlier than the cycle after response handoff.
- Arithmetic: the issuer performs no arithmetic on results. rsp_data is ARITH_OUT bit-exact (signed, two's complement, division truncates toward zero).
- Reset mid-operation: any state returns to IDLE immediately and all outputs take reset values. No pending response survives reset.
- Arith_Flag seen while in IDLE/ISSUE/RESP is ignored.

Decomposition:
- Shared package arith_pkg:
  - function-code constants FUN_ADD=2'b00, FUN_SUB=2'b01, FUN_MUL=2'b10, FUN_DIV=2'b11
  - error codes ERR_OK=2'b00, ERR_DIV0=2'b01, ERR_TIMEOUT=2'b10
  - FSM state encoding
- No sub-module required. The timeout counter and FSM live in one module.
- Bench instantiates the issuer with the arithmetic unit as the DUT pair, plus a stub with Arith_Flag tied low for timeout.

Test Plan:
- Add: cmd a=100, b=-30, fun=00; rsp_ready=1 → ARITH_Enable high exactly one cycle; rsp_valid 3 cycles after acceptance; rsp_data=70, rsp_err=00; ops_done=1.
- Multiply: a=-300, b=200, fun=10 → rsp_data=0xFFFF15A0 (-60000), rsp_err=00.
- Divide and div-by-zero:
  - a=-7, b=2, fun=11 → rsp_data=0xFFFFFFFD (-3).
  - Then a=7, b=0, fun=11 → ARITH_Enable never asserts; rsp_valid one cycle after acceptance; rsp_data=0, rsp_err=01.
- Backpressure: a=5, b=3, fun=01, rsp_ready low 5 cycles → rsp_valid, rsp_data=2 and rsp_err stable throughout; cmd_ready=0; a second cmd_valid is not accepted until one cycle after handoff.
- Timeout: stub holds Arith_Flag=0, any valid command → after TIMEOUT=4 WAIT cycles, rsp_valid with rsp_data=0, rsp_err=10.
- Reset mid-WAIT: assert rst asynchronously during WAIT → all outputs zero immediately, cmd_ready=1, ops_done=0; no response emitted after release.
